// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/halfword/word load-store front end for a word-only data memory.
// Sub-word stores are a two-cycle read-modify-write (IDLE latches the merge, WRITE commits it).
// Optional misalignment trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit #(
    parameter int WORDS_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_pos,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        misalign,
    output logic [31:0] bad_addr
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;
    localparam logic [31:0] ADDR_MASK = ((32'd1 << (WORDS_LOG2 + 2)) - 32'd1) & ~32'd3;

    logic [0:0]  state_q, state_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] addr_q, addr_d;
    logic        idle, acc, mis, is_byte, is_half, is_word, sub_st;
    logic [4:0]  bsh, hsh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_ext, merged, aligned;

    // Decode the request, extract/extend load lanes and build the sub-word merge word.
    always_comb begin
        idle     = state_q == IDLE;
        acc      = req_valid && idle;
        is_byte  = req_size == 2'b00;
        is_half  = req_size == 2'b01;
        is_word  = req_size[1];
        aligned  = {req_addr[31:2], 2'b00} & ADDR_MASK;
        bsh      = {~req_addr[1:0], 3'b000};
        hsh      = {~req_addr[1], 4'b0000};
        byte_v   = 8'(mem_rdata >> bsh);
        half_v   = 16'(mem_rdata >> hsh);
        load_ext = is_byte ? {{24{req_signed && byte_v[7]}}, byte_v}
                 : is_half ? {{16{req_signed && half_v[15]}}, half_v}
                 : mem_rdata;
        merged   = is_byte ? (mem_rdata & ~(32'hFF << bsh)) | ({24'h0, req_wdata[7:0]} << bsh)
                 : (mem_rdata & ~(32'hFFFF << hsh)) | ({16'h0, req_wdata[15:0]} << hsh);
        sub_st   = acc && req_wr && !is_word && !mis;
    end

    // Memory-side and handshake outputs; writes are blocked while reset is held.
    always_comb begin
        req_ready   = idle;
        stall       = !idle || sub_st;
        mem_pos     = idle ? aligned : addr_q;
        mem_wdata   = idle ? req_wdata : merge_q;
        mem_wr      = rst_n && (idle ? (acc && req_wr && is_word && !mis) : 1'b1);
        state_d     = sub_st ? WRITE : IDLE;
        rsp_valid_d = acc && !req_wr && !mis;
        rsp_rdata_d = rsp_valid_d ? load_ext : rsp_rdata_q;
        merge_d     = sub_st ? merged : merge_q;
        addr_d      = sub_st ? aligned : addr_q;
    end

    // FSM, load response and read-modify-write holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            merge_q     <= 32'h0;
            addr_q      <= 32'h0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            merge_q     <= merge_d;
            addr_q      <= addr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_q;
    logic [31:0] bad_addr_q;

    assign mis = req_valid && ((is_half && req_addr[0]) || (is_word && req_addr[1:0] != 2'b00));

    // Fault pulse and sticky faulting address for misaligned accepted requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
            bad_addr_q <= 32'h0;
        end else begin
            misalign_q <= acc && mis;
            bad_addr_q <= (acc && mis) ? req_addr : bad_addr_q;
        end
    end

    assign misalign = misalign_q;
    assign bad_addr = bad_addr_q;
`else
    assign mis      = 1'b0;
    assign misalign = 1'b0;
    assign bad_addr = 32'h0;
`endif
endmodule
